// File: rtl/uart_start_detect_pkg.sv
// Shared definitions for the UART receive front end: FSM states, oversample
// defaults and the start-bit vote helper.
package uart_start_detect_pkg;

   localparam int OSR_DEFAULT = 16;
   localparam int MID_OFFSET  = OSR_DEFAULT / 2;

   typedef enum logic [2:0] {
      IDLE,
      VERIFY,
      ARM,
      WAIT,
      STOP
   } rx_state_t;

   // Two or more low samples confirm the start bit.
   function automatic logic vote_low(input logic a, input logic b, input logic c);
      return (!a && !b) || (!a && !c) || (!b && !c);
   endfunction

endpackage

// File: rtl/uart_start_detect_bit_sync.sv
// STAGES-deep flop chain bringing an asynchronous level into the clk domain;
// every stage resets to RESET_VAL (idle-high for a UART line).
module bit_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst)
         chain <= {STAGES{RESET_VAL}};
      else
         // NOTE: non-blocking so each stage takes its predecessor's pre-edge value.
         chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_start_detect.sv
// UART RX front end: synchronises the pin, finds a start-bit falling edge,
// confirms it by a 3-sample mid-bit vote and then waits out the frame.
module uart_start_detect
   import uart_start_detect_pkg::*;
#(
   parameter int OSR         = OSR_DEFAULT,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = $clog2(OSR) + 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_rx,
   input  logic i_busy,
   output logic o_rx_sync,
   output logic o_start,
   output logic o_false_start,
   output logic o_break,
   output logic o_active
);

   // Default mid-bit offset scaled to this OSR (exact for any even OSR).
   localparam int MID = MID_OFFSET * OSR / OSR_DEFAULT;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(MID);
   localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(MID + 1);
   localparam logic [CNT_W-1:0] BRK_LAST = CNT_W'(OSR - 1);
   localparam logic [CNT_W-1:0] BRK_FULL = CNT_W'(OSR);

   rx_state_t        state;
   logic [CNT_W-1:0] count;
   logic             prev;
   logic             samp_a;
   logic             samp_b;
   logic             rx_sync;

   bit_sync #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (i_clk),
      .rst (i_rst),
      .d   (i_rx),
      .q   (rx_sync)
   );

   assign o_rx_sync = rx_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         count         <= '0;
         prev          <= 1'b1;
         samp_a        <= 1'b1;
         samp_b        <= 1'b1;
         o_start       <= 1'b0;
         o_false_start <= 1'b0;
         o_break       <= 1'b0;
         o_active      <= 1'b0;
      end else begin
         // NOTE: pulses default low every clock so each is exactly one cycle wide.
         o_start       <= 1'b0;
         o_false_start <= 1'b0;
         o_break       <= 1'b0;

         if (i_en) begin
            prev <= rx_sync;
            case (state)
               IDLE: begin
                  if (prev && !rx_sync) begin
                     state    <= VERIFY;
                     count    <= CNT_ONE;
                     o_active <= 1'b1;
                  end
               end

               VERIFY: begin
                  count <= count + CNT_ONE;
                  if (count == SAMPLE_A) samp_a <= rx_sync;
                  if (count == SAMPLE_B) samp_b <= rx_sync;
                  if (count == SAMPLE_C) begin
                     if (vote_low(samp_a, samp_b, rx_sync)) begin
                        o_start <= 1'b1;
                        state   <= ARM;
                     end else begin
                        o_false_start <= 1'b1;
                        state         <= IDLE;
                        o_active      <= 1'b0;
                     end
                  end
               end

               // Give the data stage one tick to claim the frame.
               ARM: begin
                  count <= '0;
                  state <= i_busy ? WAIT : STOP;
               end

               WAIT: begin
                  if (!i_busy) begin
                     state <= STOP;
                     count <= '0;
                  end
               end

               STOP: begin
                  if (rx_sync) begin
                     state    <= IDLE;
                     prev     <= 1'b1;
                     o_active <= 1'b0;
                  end else if (count != BRK_FULL) begin
                     count <= count + CNT_ONE;
                     if (count == BRK_LAST) o_break <= 1'b1;
                  end
               end

               default: begin
                  state    <= IDLE;
                  o_active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
